// File: rtl/action_executor.sv
// Runs one timed pet action per four-phase exec handshake, stepping an
// animation frame on every one-second tick and counting completed actions.
module action_executor #(
    parameter int unsigned CLOCK_FREQ = 50,
    parameter int unsigned FEED_SECS  = 3,
    parameter int unsigned PLAY_SECS  = 5,
    parameter int unsigned CLEAN_SECS = 4,
    parameter int unsigned HEAL_SECS  = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exec,
    input  logic [1:0]  selected,
    output logic        exec_status,
    output logic        busy,
    output logic [1:0]  active_action,
    output logic [1:0]  anim_frame,
    output logic        abort_pulse,
    output logic [15:0] done_count
);

    localparam int unsigned PRESC_W = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
    localparam int unsigned TICK_W  = 8;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [PRESC_W-1:0]  presc_q;
    logic [TICK_W-1:0]   ticks_q;
    logic [CNT_W-1:0]    done_cnt_q;
    logic [TICK_W-1:0]   duration_c;
    logic                tick_c;
    logic                finish_c;
    logic                start_c;
    logic                abort_c;

    assign done_count = done_cnt_q;

    // Duration of the latched action, in ticks
    always_comb begin
        duration_c = TICK_W'(FEED_SECS);
        case (active_action)
            2'd0:    duration_c = TICK_W'(FEED_SECS);
            2'd1:    duration_c = TICK_W'(PLAY_SECS);
            2'd2:    duration_c = TICK_W'(CLEAN_SECS);
            default: duration_c = TICK_W'(HEAL_SECS);
        endcase
    end

    assign tick_c   = (state_q == RUN) && (presc_q == PRESC_W'(CLOCK_FREQ - 1));
    assign finish_c = tick_c && ((ticks_q + TICK_W'(1)) == duration_c);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a dropped exec in RUN takes priority over completion
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        abort_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (exec) begin
                    state_d = RUN;
                    start_c = 1'b1;
                end
            end
            RUN: begin
                if (!exec) begin
                    state_d = IDLE;
                    abort_c = 1'b1;
                end else if (finish_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!exec) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered status flags, decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            exec_status <= 1'b0;
            abort_pulse <= 1'b0;
        end else begin
            busy        <= (state_d == RUN);
            exec_status <= (state_d == DONE);
            abort_pulse <= abort_c;
        end
    end

    // Prescaler, tick counter, animation frame and latched action code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_action <= 2'd0;
            presc_q       <= '0;
            ticks_q       <= '0;
            anim_frame    <= 2'd0;
        end else if (start_c) begin
            active_action <= selected;
            presc_q       <= '0;
            ticks_q       <= '0;
            anim_frame    <= 2'd0;
        end else if (state_d == IDLE) begin
            presc_q    <= '0;
            ticks_q    <= '0;
            anim_frame <= 2'd0;
        end else if (state_q == RUN) begin
            if (tick_c) begin
                presc_q    <= '0;
                ticks_q    <= ticks_q + TICK_W'(1);
                anim_frame <= anim_frame + 2'd1;
            end else begin
                presc_q <= presc_q + PRESC_W'(1);
            end
        end
    end

    // Completed-action counter, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt_q <= '0;
        end else if ((state_q == RUN) && (state_d == DONE) && (done_cnt_q != '1)) begin
            done_cnt_q <= done_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_action_executor.sv
// Directed self-checking bench for action_executor with CLOCK_FREQ=4.
module tb_action_executor;

    logic        clk;
    logic        rst;
    logic        exec;
    logic [1:0]  selected;
    logic        exec_status;
    logic        busy;
    logic [1:0]  active_action;
    logic [1:0]  anim_frame;
    logic        abort_pulse;
    logic [15:0] done_count;

    int checks   = 0;
    int failures = 0;
    int nbusy;

    action_executor #(
        .CLOCK_FREQ(4),
        .FEED_SECS (3),
        .PLAY_SECS (5),
        .CLEAN_SECS(4),
        .HEAL_SECS (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .exec         (exec),
        .selected     (selected),
        .exec_status  (exec_status),
        .busy         (busy),
        .active_action(active_action),
        .anim_frame   (anim_frame),
        .abort_pulse  (abort_pulse),
        .done_count   (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise exec from a negedge, count busy cycles until exec_status (bounded)
    task automatic run_action(input logic [1:0] sel, input logic [1:0] sel_during,
                              output int busy_cycles);
        selected    = sel;
        exec        = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            selected = sel_during;
            if (exec_status) break;
            if (busy) busy_cycles++;
        end
    endtask

    task automatic drop_exec();
        exec = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        exec     = 1'b0;
        selected = 2'd0;
        repeat (2) @(negedge clk);
        check("reset_exec_status", 16'(exec_status), 16'd0);
        check("reset_busy",        16'(busy),        16'd0);
        check("reset_done_count",  done_count,       16'd0);
        check("reset_anim",        16'(anim_frame),  16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Feed: 3 ticks * 4 cycles
        run_action(2'd0, 2'd0, nbusy);
        check("feed_busy_cycles",  16'(nbusy),       16'd12);
        check("feed_exec_status",  16'(exec_status), 16'd1);
        check("feed_busy_in_done", 16'(busy),        16'd0);
        check("feed_done_count",   done_count,       16'd1);
        drop_exec();
        check("feed_ack_low",      16'(exec_status), 16'd0);

        // Heal with selected changed during the run
        run_action(2'd3, 2'd1, nbusy);
        check("heal_busy_cycles",  16'(nbusy),         16'd24);
        check("heal_active",       16'(active_action), 16'd3);
        check("heal_done_count",   done_count,         16'd2);
        drop_exec();

        // Clean: frame steps every 4 cycles, 0,1,2,3,0
        selected = 2'd2;
        exec     = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            check($sformatf("clean_anim_k%0d", k), 16'(anim_frame), 16'(((k - 1) / 4) % 4));
        end
        check("clean_exec_status", 16'(exec_status), 16'd1);
        check("clean_done_count",  done_count,       16'd3);
        drop_exec();

        // Play aborted after 7 cycles
        selected = 2'd1;
        exec     = 1'b1;
        repeat (7) @(negedge clk);
        check("play_anim_pre",   16'(anim_frame), 16'd1);
        check("play_busy_pre",   16'(busy),       16'd1);
        exec = 1'b0;
        @(negedge clk);
        check("abort_pulse_hi",  16'(abort_pulse), 16'd1);
        check("abort_busy",      16'(busy),        16'd0);
        check("abort_anim",      16'(anim_frame),  16'd0);
        check("abort_status",    16'(exec_status), 16'd0);
        @(negedge clk);
        check("abort_pulse_lo",  16'(abort_pulse), 16'd0);
        check("abort_done_count", done_count,      16'd3);
        check("abort_status2",   16'(exec_status), 16'd0);

        // Asynchronous reset in the middle of a run
        selected = 2'd1;
        exec     = 1'b1;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_busy",         16'(busy),          16'd0);
        check("rst_active",       16'(active_action), 16'd0);
        check("rst_done_count",   done_count,         16'd0);
        check("rst_abort",        16'(abort_pulse),   16'd0);
        exec = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_action(2'd1, 2'd1, nbusy);
        check("post_rst_busy_cycles", 16'(nbusy),       16'd20);
        check("post_rst_done_count",  done_count,       16'd1);
        drop_exec();

        // Saturation of the completion counter
        force dut.done_cnt_q = 16'hFFFE;
        #1 release dut.done_cnt_q;
        run_action(2'd0, 2'd0, nbusy);
        check("sat_first",  done_count, 16'hFFFF);
        drop_exec();
        run_action(2'd0, 2'd0, nbusy);
        check("sat_second", done_count, 16'hFFFF);
        check("sat_busy_cycles", 16'(nbusy), 16'd12);
        drop_exec();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/action_executor.md
ACTION_EXECUTOR -- requirements
Module: action_executor

Interface
REQ-001 Parameter CLOCK_FREQ, default 50, clk cycles per one-second tick.
REQ-002 Parameters FEED_SECS=3, PLAY_SECS=5, CLEAN_SECS=4, HEAL_SECS=6, default as given, action durations in ticks; each SHALL be 1..255.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 exec  input  1  request level from the companion menu; held high until acknowledged.
REQ-006 selected  input  2  action code: 0 feed, 1 play, 2 clean, 3 heal.
REQ-007 exec_status  output  1  acknowledge; high = action completed.
REQ-008 busy  output  1  high while an action is running.
REQ-009 active_action  output  2  code latched at action start.
REQ-010 anim_frame  output  2  animation frame index for the display.
REQ-011 abort_pulse  output  1  one-cycle pulse when a running action is abandoned.
REQ-012 done_count  output  16  completed actions, saturating.

Function
REQ-013 Four-phase handshake: exec rise -> run -> exec_status high -> exec fall -> exec_status low.
REQ-014 FSM states: IDLE, RUN, DONE; encoding free.
REQ-015 IDLE: exec sampled high -> RUN same edge; selected latched into active_action; prescaler, tick count, anim_frame cleared to 0.
REQ-016 RUN: prescaler counts 0..CLOCK_FREQ-1 then wraps; each wrap is one tick; tick count +1, anim_frame +1 modulo 4.
REQ-017 RUN: selected changes ignored; active_action held constant.
REQ-018 RUN: tick count reaching the latched duration -> DONE; exec_status registered high exactly duration*CLOCK_FREQ cycles after the edge entering RUN.
REQ-019 DONE entry: done_count +1, saturating at 16'hFFFF.
REQ-020 DONE: exec_status held high while exec high; exec sampled low -> IDLE, exec_status low the following cycle.
REQ-021 RUN with exec sampled low (abort) -> IDLE; abort_pulse high exactly one cycle; exec_status never asserted; done_count unchanged.
REQ-022 Abort and completion on the same edge: abort wins.
REQ-023 busy = 1 exactly in RUN; exec_status = 1 exactly in DONE; both registered/decoded from state, glitch-free.
REQ-024 IDLE: anim_frame holds 0; active_action holds the last latched code.
REQ-025 exec held high after DONE->IDLE is impossible (DONE leaves only on exec low); a new exec rise in IDLE starts a new action with no dead cycle required.
REQ-026 Prescaler width: ceil(log2(CLOCK_FREQ)) bits minimum; tick count 8 bits; no other wrap.

Reset
REQ-027 rst high forces IDLE asynchronously; exec_status=0, busy=0, active_action=0, anim_frame=0, abort_pulse=0, done_count=0, prescaler=0, tick count=0.
REQ-028 Reset mid-RUN or mid-DONE abandons the action without abort_pulse and without counting.
REQ-029 After rst falls, first exec sample on the next rising edge.

Verification (CLOCK_FREQ=4)
REQ-030 Feed: selected=0, exec high held -> busy 12 cycles, exec_status high on cycle 12, done_count=1; drop exec -> exec_status low next cycle.
REQ-031 Heal with selected switched to 1 during RUN -> active_action stays 3, exec_status after 24 cycles.
REQ-032 Play, exec dropped at cycle 7 -> one-cycle abort_pulse, anim_frame back to 0, exec_status never high, done_count unchanged.
REQ-033 anim_frame during clean run: 0,1,2,3,0 stepping every 4 cycles.
REQ-034 rst asserted mid-RUN between edges -> all outputs 0 immediately; next exec starts clean 12/20/16/24-cycle run.
REQ-035 Force done_count to 16'hFFFE, complete two actions -> stays 16'hFFFF.
